// File: rtl/encoder_4_2_sync_if.sv
// Request/code bus between the board-input side and the registered 4-to-2 encoder.
// The master drives the request lines, enable and acknowledge. The slave returns the code and status.
interface encoder_4_2_sync_if;
  logic [3:0] I;
  logic       E;
  logic       ACK;
  logic [1:0] Y;
  logic       V;
  logic       ERR;
  logic       GS;
  logic       BUSY;

  modport master (output I, E, ACK, input Y, V, ERR, GS, BUSY);
  modport slave  (input I, E, ACK, output Y, V, ERR, GS, BUSY);
endinterface

// File: rtl/encoder_4_2_sync.sv
// Registered 4-to-2 priority encoder with input synchroniser, debounce and a valid/ack handshake.
// Each press of a request line produces exactly one held code.
module encoder_4_2_sync #(
  parameter int DEB_CNT = 4,
  parameter int CNT_W   = 8
) (
  input logic               clk,
  input logic               rst_n,
  encoder_4_2_sync_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] CAPTURED = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);

  logic [3:0]       sync_q;
  logic [3:0]       i_s;
  logic [3:0]       sample;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;
  logic [1:0]       y_q;
  logic             v_q;
  logic             err_q;
  logic             gs_q;

  function automatic logic [1:0] encode(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    if (v[3])      r = 2'd3;
    else if (v[2]) r = 2'd2;
    else if (v[1]) r = 2'd1;
    return r;
  endfunction

  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 4'd0;
      i_s    <= 4'd0;
    end else begin
      sync_q <= bus.I;
      i_s    <= sync_q;
    end
  end

  // Disabling the block overrides everything else. The synchroniser above keeps running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sample <= 4'd0;
      cnt    <= '0;
      y_q    <= 2'd0;
      v_q    <= 1'b0;
      err_q  <= 1'b0;
      gs_q   <= 1'b0;
    end else begin
      gs_q <= bus.E && (i_s != 4'd0);
      if (!bus.E) begin
        state  <= IDLE;
        sample <= 4'd0;
        cnt    <= '0;
        y_q    <= 2'd0;
        v_q    <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_s != 4'd0) begin
              sample <= i_s;
              cnt    <= '0;
              state  <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (i_s == sample) begin
              if (cnt == DEB_LAST) begin
                y_q   <= encode(sample);
                err_q <= multi_hot(sample);
                v_q   <= 1'b1;
                state <= CAPTURED;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else if (i_s != 4'd0) begin
              sample <= i_s;
              cnt    <= '0;
            end else begin
              state <= IDLE;
            end
          end
          CAPTURED: begin
            if (bus.ACK) begin
              v_q   <= 1'b0;
              err_q <= 1'b0;
              state <= RELEASE;
            end
          end
          RELEASE: begin
            // A line still held after the acknowledge must drop before it can be captured again.
            if (i_s == 4'd0) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.Y    = y_q;
  assign bus.V    = v_q;
  assign bus.ERR  = err_q;
  assign bus.GS   = gs_q;
  assign bus.BUSY = (state != IDLE);

endmodule

// File: tb/tb_encoder_4_2_sync.sv
// Self-checking bench for encoder_4_2_sync: directed press scenarios plus randomised traffic.
// All traffic is compared against a press-tracking reference model.
module tb_encoder_4_2_sync;

  localparam int DEB = 4;

  logic clk;
  logic rst_n;
  encoder_4_2_sync_if bus ();

  encoder_4_2_sync #(.DEB_CNT(DEB), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errorCount = 0;
  int checkCount = 0;

  // Reference model: a two-deep delay line of raw inputs plus a description of the current press.
  logic [3:0] dly [2];
  logic [3:0] cand;
  int         runLen;
  bit         tracking, holding, waitRelease;
  logic [1:0] mY;
  bit         mErr, mGs;

  task automatic modelReset();
    dly[0] = 4'd0; dly[1] = 4'd0; cand = 4'd0; runLen = 0;
    tracking = 0; holding = 0; waitRelease = 0; mY = 2'd0; mErr = 0; mGs = 0;
  endtask

  task automatic modelEdge(input logic [3:0] i, input bit e, input bit ack);
    logic [3:0] seen;
    int hi, ones;
    seen = dly[1];
    mGs = e && (seen != 4'd0);
    if (!e) begin
      tracking = 0; holding = 0; waitRelease = 0; mY = 2'd0; mErr = 0; runLen = 0;
    end else if (holding) begin
      if (ack) begin holding = 0; mErr = 0; waitRelease = 1; end
    end else if (waitRelease) begin
      if (seen == 4'd0) waitRelease = 0;
    end else if (tracking) begin
      if (seen == cand) begin
        if (runLen + 1 >= DEB) begin
          hi = 0; ones = 0;
          for (int b = 0; b < 4; b++) if (cand[b]) begin hi = b; ones++; end
          mY = 2'(hi); mErr = (ones > 1); holding = 1; tracking = 0;
        end else runLen++;
      end else if (seen != 4'd0) begin
        cand = seen; runLen = 0;
      end else tracking = 0;
    end else if (seen != 4'd0) begin
      tracking = 1; cand = seen; runLen = 0;
    end
    dly[1] = dly[0];
    dly[0] = i;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("Y",    32'(bus.Y),    32'(mY));
    checkOutput("V",    32'(bus.V),    32'(holding));
    checkOutput("ERR",  32'(bus.ERR),  32'(mErr));
    checkOutput("GS",   32'(bus.GS),   32'(mGs));
    checkOutput("BUSY", 32'(bus.BUSY), 32'(tracking | holding | waitRelease));
  endtask

  // Drive inputs away from the edge, advance one clock, then compare on the falling edge.
  task automatic applyStimulus(input logic [3:0] i, input bit e, input bit ack, input bit rstn);
    bus.I = i; bus.E = e; bus.ACK = ack; rst_n = rstn;
    if (!rstn) modelReset();
    @(posedge clk);
    if (rstn) modelEdge(i, e, ack);
    @(negedge clk);
    compareAll();
  endtask

  task automatic pulseReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, "_V"},    32'(bus.V),    32'd0);
    checkOutput({tag, "_Y"},    32'(bus.Y),    32'd0);
    checkOutput({tag, "_ERR"},  32'(bus.ERR),  32'd0);
    checkOutput({tag, "_GS"},   32'(bus.GS),   32'd0);
    checkOutput({tag, "_BUSY"}, 32'(bus.BUSY), 32'd0);
    modelReset();
    applyStimulus(bus.I, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] ri;
    int holdLeft;
    bus.I = 4'd0; bus.E = 1'b1; bus.ACK = 1'b0; rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    applyStimulus(4'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("rstV", 32'(bus.V), 32'd0);
    checkOutput("rstBUSY", 32'(bus.BUSY), 32'd0);

    // Single held press: V rises on edge DEB+3 and GS on edge 3.
    for (int edgeNo = 1; edgeNo <= 7; edgeNo++) begin
      applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1);
      if (edgeNo == 2) checkOutput("gsEarly", 32'(bus.GS), 32'd0);
      if (edgeNo == 3) checkOutput("gsEdge3", 32'(bus.GS), 32'd1);
      if (edgeNo == 6) checkOutput("vEarly", 32'(bus.V), 32'd0);
    end
    checkOutput("vEdge7", 32'(bus.V), 32'd1);
    checkOutput("yEdge7", 32'(bus.Y), 32'd2);
    checkOutput("errEdge7", 32'(bus.ERR), 32'd0);

    applyStimulus(4'b0100, 1'b1, 1'b1, 1'b1);
    checkOutput("ackV", 32'(bus.V), 32'd0);
    checkOutput("ackBUSY", 32'(bus.BUSY), 32'd1);
    for (int k = 0; k < 5; k++) applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1);
    checkOutput("noSecondV", 32'(bus.V), 32'd0);
    applyStimulus(4'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("relBusy2", 32'(bus.BUSY), 32'd1);
    applyStimulus(4'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("relBusy3", 32'(bus.BUSY), 32'd0);

    // Multi-hot press, ACK held the whole time, then a lowest-priority press.
    for (int k = 0; k < 8; k++) applyStimulus(4'b1010, 1'b1, 1'b1, 1'b1);
    checkOutput("multiY", 32'(bus.Y), 32'd3);
    for (int k = 0; k < 5; k++) applyStimulus(4'd0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 7; k++) applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1);
    checkOutput("lowY", 32'(bus.Y), 32'd0);
    checkOutput("lowV", 32'(bus.V), 32'd1);
    checkOutput("lowERR", 32'(bus.ERR), 32'd0);
    applyStimulus(4'b0001, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus(4'd0, 1'b1, 1'b0, 1'b1);

    // Short glitch never captures; a change mid-debounce restarts the count.
    for (int k = 0; k < 3; k++) applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) applyStimulus(4'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("glitchBUSY", 32'(bus.BUSY), 32'd0);
    for (int k = 0; k < 4; k++) applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) applyStimulus(4'b0010, 1'b1, 1'b0, 1'b1);
    checkOutput("restartV", 32'(bus.V), 32'd1);
    checkOutput("restartY", 32'(bus.Y), 32'd1);

    // Disable while CAPTURED with a simultaneous ACK, then disabled with a line active.
    applyStimulus(4'b0010, 1'b0, 1'b1, 1'b1);
    checkOutput("disV", 32'(bus.V), 32'd0);
    checkOutput("disGS", 32'(bus.GS), 32'd0);
    checkOutput("disBUSY", 32'(bus.BUSY), 32'd0);
    for (int k = 0; k < 10; k++) applyStimulus(4'b0010, 1'b0, 1'b0, 1'b1);
    checkOutput("disNoCap", 32'(bus.V), 32'd0);

    // Asynchronous reset during DEBOUNCE and during CAPTURED.
    for (int k = 0; k < 4; k++) applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1);
    pulseReset("rstDeb");
    for (int k = 0; k < 8; k++) applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1);
    pulseReset("rstCap");
    for (int edgeNo = 1; edgeNo <= 7; edgeNo++) begin
      applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1);
      if (edgeNo == 6) checkOutput("postRstEarly", 32'(bus.V), 32'd0);
    end
    checkOutput("postRstV", 32'(bus.V), 32'd1);

    // Randomised traffic: held request patterns, sparse disables, random acknowledges, rare resets.
    ri = 4'd0;
    holdLeft = 0;
    for (int n = 0; n < 600; n++) begin
      if (holdLeft == 0) begin
        ri = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        holdLeft = $urandom_range(1, 12);
      end
      holdLeft--;
      applyStimulus(ri, $urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 99) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
